// File: rtl/router4_grant_arbiter.sv
// Round-robin packet grant scheduler for the three merges of the 4-port router.
// Optional watchdog release enabled by defining GRANT_TIMEOUT_EN.
module router4_merge_arb #(
    parameter int PKT_FLITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       proto_err,
    output logic       timeout_err
);
    localparam int CW = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_FLITS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          cur;
    logic [1:0]    pick_now;
    logic [1:0]    pick_next;

    // With both requesting, the one not served last wins
    function automatic logic [1:0] pick(input logic [1:0] r, input logic lst);
        logic [1:0] g;
        g = 2'b00;
        case (r)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = lst ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    assign cur       = gnt[1];
    assign pick_now  = pick(req, last);
    assign pick_next = pick(req, cur);
    assign busy      = |gnt;

`ifdef GRANT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            cnt         <= '0;
            last        <= 1'b1;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
            idle        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) proto_err <= 1'b1;
                    if (|req) begin
                        gnt   <= pick_now;
                        state <= BUSY;
                        idle  <= '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        idle <= '0;
                        if (cnt == CNT_LAST) begin
                            cnt  <= '0;
                            last <= cur;
                            gnt  <= pick_next;
                            if (!(|req)) state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (idle == IDLE_LAST) begin
                        gnt         <= 2'b00;
                        cnt         <= '0;
                        last        <= cur;
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            cnt       <= '0;
            last      <= 1'b1;
            proto_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) proto_err <= 1'b1;
                    if (|req) begin
                        gnt   <= pick_now;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (cnt == CNT_LAST) begin
                            cnt  <= '0;
                            last <= cur;
                            gnt  <= pick_next;
                            if (!(|req)) state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

module router4_grant_arbiter #(
    parameter int PKT_FLITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] p_req,
    input  logic [1:0] c1_req,
    input  logic [1:0] c2_req,
    input  logic [2:0] xfer,
    output logic [1:0] p_gnt,
    output logic [1:0] c1_gnt,
    output logic [1:0] c2_gnt,
    output logic [2:0] busy,
    output logic [2:0] proto_err,
    output logic [2:0] timeout_err
);
    logic [1:0] req_a [3];
    logic [1:0] gnt_a [3];

    assign req_a[0] = p_req;
    assign req_a[1] = c1_req;
    assign req_a[2] = c2_req;
    assign p_gnt    = gnt_a[0];
    assign c1_gnt   = gnt_a[1];
    assign c2_gnt   = gnt_a[2];

    for (genvar i = 0; i < 3; i++) begin : g_arb
        router4_merge_arb #(
            .PKT_FLITS(PKT_FLITS),
            .TIMEOUT  (TIMEOUT)
        ) u_arb (
            .clk        (CLK),
            .rst        (RESET),
            .req        (req_a[i]),
            .xfer       (xfer[i]),
            .gnt        (gnt_a[i]),
            .busy       (busy[i]),
            .proto_err  (proto_err[i]),
            .timeout_err(timeout_err[i])
        );
    end
endmodule

// File: tb/tb_router4_grant_arbiter.sv
// Bench for router4_grant_arbiter: packet-level model checked every cycle
// plus hand-computed checkpoints from the test plan.
module tb_router4_grant_arbiter;
    localparam int PKT = 4;
    localparam int TO  = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] p_req = 2'b00, c1_req = 2'b00, c2_req = 2'b00;
    logic [2:0] xfer = 3'b000;
    logic [1:0] p_gnt, c1_gnt, c2_gnt;
    logic [2:0] busy, proto_err, timeout_err;

    int passed = 0;
    int total  = 0;

    int owner [3];
    int flits [3];
    int lastw [3];
    int idlec [3];
    int perr  [3];
    int terr  [3];

    router4_grant_arbiter #(.PKT_FLITS(PKT), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .p_req(p_req), .c1_req(c1_req), .c2_req(c2_req),
        .xfer(xfer),
        .p_gnt(p_gnt), .c1_gnt(c1_gnt), .c2_gnt(c2_gnt),
        .busy(busy), .proto_err(proto_err), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int req_of(input int o);
        if (o == 0) return int'(p_req);
        if (o == 1) return int'(c1_req);
        return int'(c2_req);
    endfunction

    function automatic int gnt_of(input int o);
        if (o == 0) return int'(p_gnt);
        if (o == 1) return int'(c1_gnt);
        return int'(c2_gnt);
    endfunction

    function automatic int pick(input int r, input int lst);
        if (r == 1) return 0;
        if (r == 2) return 1;
        if (r == 3) return 1 - lst;
        return -1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            owner[o] = -1; flits[o] = 0; lastw[o] = 1;
            idlec[o] = 0; perr[o] = 0; terr[o] = 0;
        end
    endtask

    task automatic model_step();
        if (RESET) begin
            model_reset();
            return;
        end
        for (int o = 0; o < 3; o++) begin
            int r;
            bit x;
            r = req_of(o);
            x = xfer[o];
            if (owner[o] < 0) begin
                if (x) perr[o] = 1;
                if (r != 0) begin
                    owner[o] = pick(r, lastw[o]);
                    idlec[o] = 0;
                end
            end else if (x) begin
                idlec[o] = 0;
                flits[o]++;
                if (flits[o] == PKT) begin
                    flits[o] = 0;
                    lastw[o] = owner[o];
                    owner[o] = pick(r, lastw[o]);
                end
            end else begin
`ifdef GRANT_TIMEOUT_EN
                if (idlec[o] == TO - 1) begin
                    lastw[o] = owner[o];
                    owner[o] = -1;
                    flits[o] = 0;
                    terr[o]  = 1;
                end else begin
                    idlec[o]++;
                end
`endif
            end
        end
    endtask

    task automatic compare();
        for (int o = 0; o < 3; o++) begin
            int eg;
            eg = (owner[o] < 0) ? 0 : (1 << owner[o]);
            chk($sformatf("gnt[%0d]", o), gnt_of(o), eg);
            chk($sformatf("busy[%0d]", o), int'(busy[o]), int'(owner[o] >= 0));
            chk($sformatf("proto_err[%0d]", o), int'(proto_err[o]), perr[o]);
            chk($sformatf("timeout_err[%0d]", o), int'(timeout_err[o]), terr[o]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare();
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        RESET = 1'b0;
        chk("reset_gnt", int'({p_gnt, c1_gnt, c2_gnt}), 0);
        chk("reset_flags", int'({busy, proto_err, timeout_err}), 0);

        // single requester, one packet
        p_req = 2'b01;
        tick();
        chk("p_first_gnt", int'(p_gnt), 1);
        chk("p_busy", int'(busy[0]), 1);
        p_req = 2'b00;
        xfer  = 3'b001;
        repeat (3) tick();
        chk("p_hold_3", int'(p_gnt), 1);
        tick();
        chk("p_release", int'(p_gnt), 0);
        xfer = 3'b000;
        tick();

        // contention, back-to-back packets
        c1_req = 2'b11;
        tick();
        chk("c1_pkt1", int'(c1_gnt), 1);
        xfer = 3'b010;
        repeat (3) tick();
        chk("c1_pkt1_end", int'(c1_gnt), 1);
        tick();
        chk("c1_pkt2", int'(c1_gnt), 2);
        repeat (4) tick();
        chk("c1_pkt3", int'(c1_gnt), 1);
        c1_req = 2'b00;
        repeat (4) tick();
        chk("c1_idle", int'(c1_gnt), 0);
        xfer = 3'b000;
        tick();

        // withdrawal mid-packet is ignored
        c2_req = 2'b10;
        tick();
        chk("c2_gnt", int'(c2_gnt), 2);
        c2_req = 2'b00;
        xfer   = 3'b100;
        repeat (3) tick();
        chk("c2_hold", int'(c2_gnt), 2);
        tick();
        chk("c2_release", int'(c2_gnt), 0);
        xfer = 3'b000;
        tick();

        // transfers without a grant
        xfer = 3'b111;
        tick();
        chk("proto_set", int'(proto_err), 7);
        chk("proto_nogrant", int'({p_gnt, c1_gnt, c2_gnt}), 0);
        xfer = 3'b000;
        repeat (3) tick();
        chk("proto_sticky", int'(proto_err), 7);

        // stalled packet
        p_req = 2'b01;
        tick();
        p_req = 2'b00;
`ifdef GRANT_TIMEOUT_EN
        repeat (TO - 1) tick();
        chk("to_hold", int'(p_gnt), 1);
        tick();
        chk("to_release", int'(p_gnt), 0);
        chk("to_err", int'(timeout_err[0]), 1);
        repeat (100 - TO) tick();
`else
        repeat (100) tick();
        chk("stall_hold", int'(p_gnt), 1);
        chk("stall_no_to", int'(timeout_err), 0);
`endif

        // async reset mid-packet
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        p_req = 2'b01;
        tick();
        p_req = 2'b00;
        xfer  = 3'b001;
        repeat (2) tick();
        xfer = 3'b000;
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_gnt", int'(p_gnt), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        tick();
        RESET = 1'b0;
        p_req = 2'b01;
        tick();
        p_req = 2'b00;
        xfer  = 3'b001;
        repeat (3) tick();
        chk("post_rst_hold", int'(p_gnt), 1);
        tick();
        chk("post_rst_release", int'(p_gnt), 0);
        xfer = 3'b000;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
